// File: rtl/kan_row_reducer.sv
// Snapshots one full KAN PE-array frame, reduces each row to a saturated signed
// sum one term per cycle, and streams row results through a show-ahead FIFO.
module kan_row_reducer #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = $clog2(ARRAY_SIZE)
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        enable,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_WIDTH-1:0] pe_data,
  input  logic [ARRAY_SIZE*ARRAY_SIZE-1:0]            pe_valid,
  output logic signed [DATA_WIDTH-1:0]                out_data,
  output logic [ROW_W-1:0]                            out_row,
  output logic                                        out_last,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        busy,
  output logic [$clog2(FIFO_DEPTH):0]                 fifo_level,
  output logic [15:0]                                 drop_count
);

  localparam int N     = ARRAY_SIZE;
  localparam int DW    = DATA_WIDTH;
  localparam int CELLS = N * N;
  localparam int IDX_W = $clog2(CELLS);
  localparam int ACC_W = DW + ROW_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = DW + ROW_W + 1;
  localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(N - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_PUSH} state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [DW-1:0]     r_snap [CELLS];
  logic [ROW_W-1:0]         r_row, w_row_nxt;
  logic [ROW_W-1:0]         r_col, w_col_nxt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [IDX_W-1:0]         w_idx;
  logic signed [DW-1:0]     w_term;
  logic signed [ACC_W-1:0]  w_term_ext;
  logic                     w_frame, w_accept, w_push, w_pop, w_full;
  logic [ENT_W-1:0]         r_mem [FIFO_DEPTH];
  logic [ENT_W-1:0]         w_head, w_ent;
  logic [PTR_W-1:0]         r_wptr, r_rptr;
  logic [LVL_W-1:0]         r_level;
  logic [15:0]              r_drop;

  function automatic logic signed [DW-1:0] sat_acc(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI)      return SAT_HI[DW-1:0];
    else if (a < SAT_LO) return SAT_LO[DW-1:0];
    else                 return a[DW-1:0];
  endfunction

  assign w_frame    = enable && (&pe_valid);
  assign w_accept   = (r_state == S_IDLE) && w_frame;
  assign w_idx      = IDX_W'(r_row) * IDX_W'(N) + IDX_W'(r_col);
  assign w_term     = r_snap[w_idx];
  assign w_term_ext = {{(ACC_W-DW){w_term[DW-1]}}, w_term};

  // Stage 0: frame snapshot (data only, no reset)
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < CELLS; i++) r_snap[i] <= pe_data[i*DW +: DW];
    end
  end

  // Stage 1: serial row reduction FSM
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_acc_nxt   = r_acc;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_frame) begin
          w_state_nxt = S_ACCUM;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_acc_nxt   = '0;
        end
      end
      S_ACCUM: begin
        w_acc_nxt = r_acc + w_term_ext;
        if (r_col == LAST_IDX) begin
          w_col_nxt   = '0;
          w_state_nxt = S_PUSH;
        end else begin
          w_col_nxt = r_col + ROW_W'(1);
        end
      end
      S_PUSH: begin
        // A full FIFO holds the FSM here with acc intact.
        if (!w_full) begin
          w_push    = 1'b1;
          w_acc_nxt = '0;
          if (r_row == LAST_IDX) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_row_nxt   = r_row + ROW_W'(1);
            w_state_nxt = S_ACCUM;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_acc   <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_acc   <= w_acc_nxt;
      if (w_frame && (r_state != S_IDLE) && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end
  end

  // Stage 2: output FIFO; fullness is judged before any same-cycle pop
  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign out_valid = (r_level != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_ent     = {sat_acc(r_acc), r_row, (r_row == LAST_IDX)};
  assign w_head    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign out_data   = out_valid ? w_head[ENT_W-1 -: DW] : '0;
  assign out_row    = out_valid ? w_head[ROW_W:1] : '0;
  assign out_last   = out_valid ? w_head[0] : 1'b0;
  assign busy       = (r_state != S_IDLE);
  assign fifo_level = r_level;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_kan_row_reducer.sv
// Directed bench for kan_row_reducer (N=8, DW=16, depth 4) with hand-computed row sums.
module tb_kan_row_reducer;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int FD = 4;
  localparam int RW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable = 1'b1;
  logic [N*N*DW-1:0] pe_data = '0;
  logic [N*N-1:0]    pe_valid = '0;
  logic [DW-1:0]     out_data;
  logic [RW-1:0]     out_row;
  logic              out_last, out_valid, out_ready, busy;
  logic [2:0]        fifo_level;
  logic [15:0]       drop_count;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q [N];

  kan_row_reducer #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pe_data(pe_data), .pe_valid(pe_valid),
    .out_data(out_data), .out_row(out_row), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_all(input logic [DW-1:0] v);
    for (int i = 0; i < N*N; i++) pe_data[i*DW +: DW] = v;
  endtask

  task automatic set_pe(input int r, input int c, input logic [DW-1:0] v);
    pe_data[(r*N+c)*DW +: DW] = v;
  endtask

  // PE(r,c) = m*(r+1), so row r sums to 8*m*(r+1)
  task automatic set_rows_inc(input int m);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) set_pe(r, c, DW'(m * (r + 1)));
      exp_q[r] = DW'(8 * m * (r + 1));
    end
  endtask

  task automatic fire();
    pe_valid = '1;
    step();
    pe_valid = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},  32'(out_data), 0);
    chk({tag, "_row"},   32'(out_row), 0);
    chk({tag, "_last"},  32'(out_last), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
    chk({tag, "_drop"},  32'(drop_count), 0);
  endtask

  task automatic drain(input int start, input string tag);
    int idx = start;
    int k = 0;
    while (idx < N && k < 400) begin
      if (out_valid) begin
        chk({tag, "_data"}, 32'(out_data), 32'(exp_q[idx]));
        chk({tag, "_row"},  32'(out_row), 32'(idx));
        chk({tag, "_last"}, 32'(out_last), 32'(idx == N - 1));
        idx++;
      end
      step();
      k++;
    end
    chk({tag, "_count"}, idx, N);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 300) begin
      step();
      k++;
    end
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    step(); step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // all ones: exact timing of every row
    set_all(16'h0001);
    fire();
    chk("t1_busy_start", 32'(busy), 1);
    for (int t = 1; t <= 72; t++) begin
      step();
      if (t % 9 == 0) begin
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_data",  32'(out_data), 32'h8);
        chk("t1_row",   32'(out_row), 32'(t / 9 - 1));
        chk("t1_last",  32'(out_last), 32'(t == 72));
      end else if (t % 9 == 1 || t == 8) begin
        chk("t1_novalid", 32'(out_valid), 0);
      end
      if (t == 71) chk("t1_busy_71", 32'(busy), 1);
      if (t == 72) chk("t1_busy_72", 32'(busy), 0);
    end

    // positive and negative saturation, and exact mixed sum
    set_all(16'h7000);
    for (int r = 0; r < N; r++) exp_q[r] = 16'h7FFF;
    fire(); drain(0, "t2_pos"); wait_idle("t2");

    set_all(16'h8000);
    for (int r = 0; r < N; r++) exp_q[r] = 16'h8000;
    fire(); drain(0, "t3_neg"); wait_idle("t3");

    set_all(16'h0001);
    set_pe(0, 0, 16'h7FFF);
    set_pe(0, 1, 16'h8000);
    exp_q[0] = 16'h0005;
    for (int r = 1; r < N; r++) exp_q[r] = 16'h0008;
    fire(); drain(0, "t4_mix"); wait_idle("t4");

    // FIFO fills and the FSM stalls
    set_rows_inc(1);
    out_ready = 1'b0;
    fire();
    repeat (50) step();
    chk("t5_level_full", 32'(fifo_level), 4);
    chk("t5_busy",       32'(busy), 1);
    chk("t5_head",       32'(out_data), 32'h8);
    chk("t5_head_row",   32'(out_row), 0);
    out_ready = 1'b1;
    drain(0, "t5_stall");
    chk("t5_level_empty", 32'(fifo_level), 0);
    wait_idle("t5");

    // drop while busy; enable low is not a frame
    set_rows_inc(2);
    out_ready = 1'b0;
    fire();
    repeat (9) step();
    set_all(16'h0100);
    pe_valid = '1; step(); pe_valid = '0;
    chk("t6_drop1", 32'(drop_count), 1);
    repeat (9) step();
    enable = 1'b0;
    pe_valid = '1; step(); pe_valid = '0;
    enable = 1'b1;
    chk("t6_drop_en0", 32'(drop_count), 1);
    out_ready = 1'b1;
    drain(0, "t6_keep");
    wait_idle("t6");
    enable = 1'b0;
    pe_valid = '1; step(); pe_valid = '0;
    enable = 1'b1;
    chk("t6_idle_en0_busy", 32'(busy), 0);
    chk("t6_idle_en0_drop", 32'(drop_count), 1);

    // frame on the final PUSH edge is dropped
    set_all(16'h0001);
    fire();
    repeat (71) step();
    pe_valid = '1; step(); pe_valid = '0;
    chk("t6b_drop2", 32'(drop_count), 2);
    chk("t6b_busy",  32'(busy), 0);
    step();
    chk("t6b_empty", 32'(out_valid), 0);

    // async reset mid-ACCUM of row 3 with two entries queued
    set_rows_inc(1);
    out_ready = 1'b0;
    fire();
    repeat (28) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t7_level2", 32'(fifo_level), 2);
    chk("t7_busy",   32'(busy), 1);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1 chk_zero("t7_inrst");
    step(); step();
    rst_n = 1'b1;
    step();
    chk_zero("t7_after");
    set_all(16'h0002);
    for (int r = 0; r < N; r++) exp_q[r] = 16'h0010;
    out_ready = 1'b1;
    fire(); drain(0, "t7_new"); wait_idle("t7");

    // push and pop together at a full FIFO, over several frames
    for (int f = 0; f < 3; f++) begin
      set_rows_inc(f + 1);
      out_ready = 1'b0;
      fire();
      repeat (44) step();
      chk("t8_full",     32'(fifo_level), 4);
      chk("t8_head0",    32'(out_data), 32'(exp_q[0]));
      out_ready = 1'b1;
      step();
      chk("t8_popfull",  32'(fifo_level), 3);
      chk("t8_head1",    32'(out_data), 32'(exp_q[1]));
      chk("t8_head1row", 32'(out_row), 1);
      step();
      chk("t8_pushpop",  32'(fifo_level), 3);
      drain(2, "t8_wrap");
      wait_idle("t8");
      chk("t8_level0",   32'(fifo_level), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/kan_row_reducer.md
# kan_row_reducer

Downstream consumer of the KAN systolic PE array. It captures one full frame of PE outputs (ARRAY_SIZE × ARRAY_SIZE values), sums each row's PE outputs as signed values with saturation to form the KAN node outputs, and streams the results through an output FIFO with a valid/ready handshake. The array has no backpressure, so this block snapshots the array, reduces the snapshot serially, and counts any frames it has to drop.

## Interface
- ARRAY_SIZE, 8, PE array dimension N; also the number of terms per row sum
- DATA_WIDTH, 16, PE output and reduced output width, signed two's complement
- FIFO_DEPTH, 4, output FIFO entries; must be a power of two and at least 2
- ROW_W, $clog2(ARRAY_SIZE), width of the row tag
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  when low, new frames are ignored and not counted as dropped; in-flight work completes
- pe_data  input  ARRAY_SIZE*ARRAY_SIZE*DATA_WIDTH  flattened PE outputs; element (r,c) is at bits [(r*N+c)*DW +: DW]
- pe_valid  input  ARRAY_SIZE*ARRAY_SIZE  per-PE output_valid, same (r,c) index ordering
- out_data  output  DATA_WIDTH  saturated row sum at the FIFO head
- out_row  output  ROW_W  row index of out_data
- out_last  output  1  high when out_data belongs to row N-1
- out_valid  output  1  FIFO is not empty
- out_ready  input  1  consumer accepts the head entry
- busy  output  1  FSM is not in IDLE
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- drop_count  output  16  number of frames dropped because the block was busy; saturates at 0xFFFF

## Operation
- Frame event: enable is high and every pe_valid bit is high in the same cycle.
- FSM states: IDLE, ACCUM, PUSH.
- IDLE, on a frame event: latch all of pe_data into the snapshot; set r=0, c=0, acc=0; go to ACCUM.
- ACCUM, each cycle:
  - acc += sign_extend(snap[r][c]), with acc width DATA_WIDTH+ROW_W+1 so it cannot overflow.
  - c++.
  - When c==N-1, add the last term, clear c, and go to PUSH.
- PUSH, if the FIFO is not full:
  - Write {sat(acc), r, r==N-1} and clear acc.
  - If r==N-1, go to IDLE; otherwise r++ and go to ACCUM.
- PUSH, if the FIFO is full: stay in PUSH and hold acc (stall).
- sat(): clamp to [-2^(DW-1), 2^(DW-1)-1].
- Frame event while busy: the frame is ignored and drop_count increments by 1, saturating. The snapshot is not disturbed.
- A frame event in the same cycle as the PUSH→IDLE transition is dropped. A frame is accepted only while the FSM is already in IDLE.
- FIFO:
  - Show-ahead: out_data, out_row and out_last always reflect the head entry.
  - Pop occurs when out_valid && out_ready.
  - Push is allowed only if fifo_level < FIFO_DEPTH at the start of the cycle. A pop in the same cycle does not free a slot for that cycle's push.
  - A simultaneous push and pop leaves fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Reset, asynchronous and possible mid-operation:
  - FSM goes to IDLE; r, c and acc clear; FIFO empties.
  - All outputs go to 0: out_data, out_row, out_last, out_valid, busy, fifo_level, drop_count.
  - Snapshot contents are don't-care.

## Timing
- The frame is sampled at clock edge E0. busy is high after E0.
- ACCUM occupies edges E1..EN. The PUSH write happens at edge EN+1, and out_valid rises after EN+1 if the FIFO was empty.
- Row k is written at edge E((k+1)(N+1)) when there are no stalls. A full frame takes N(N+1) cycles; for N=8 that is 72.
- busy falls after the last PUSH edge. The earliest next frame is accepted at the following edge.
- Pop takes effect at the edge where out_valid && out_ready. The new head is visible in the next cycle.
- Each stall cycle in PUSH delays every later row by one cycle.

## Test plan
- N=8, DW=16, all PE=0x0001, out_ready=1:
  - 8 outputs of 0x0008, rows 0..7, out_last only on row 7.
  - First out_valid 9 cycles after the sample edge; outputs spaced 9 cycles apart; busy high for 72 cycles.
- All PE=0x7000 → every output is 0x7FFF. All PE=0x8000 → every output is 0x8000. Row 0 = {0x7FFF, 0x8000, 0x0001 ×6} → exact sum 0x0005.
- FIFO_DEPTH=4, out_ready=0:
  - fifo_level reaches 4 and the FSM stalls in PUSH with busy high.
  - Raise out_ready → all 8 rows emerge in order with correct values; no loss or duplication.
- Second frame event 10 cycles after the first → drop_count=1 and the first frame's outputs are unchanged. Frame events with enable=0 → drop_count unchanged.
- Assert rst_n low mid-ACCUM of row 3 with 2 entries in the FIFO:
  - All outputs read 0 and the FIFO is empty.
  - A new frame of all 0x0002 after release → 8 outputs of 0x0010.
- Continuous pop under a full FIFO, with push and pop in the same cycle → fifo_level stays correct and the pointers wrap correctly over 3+ frames.
